// File: rtl/nios_system_4a_mem_pkg.sv
// Shared definitions for the on-chip memory test master: FSM encoding,
// mode bits and default geometry of the memory under test.
package nios_system_4a_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_RANGE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_FIN
    } state_t;

    localparam logic [1:0]  MODE_NOP    = 2'b00;
    localparam logic [1:0]  MODE_FILL   = 2'b01;
    localparam logic [1:0]  MODE_CHECK  = 2'b10;

    localparam int          DEF_DEPTH   = 5120;
    localparam logic [31:0] DEF_STRIDE  = 32'h01010101;
    localparam int          DEF_TIMEOUT = 255;

endpackage

// File: rtl/nios_system_4a_mem_test_master_if.sv
// Avalon-MM word-addressed bus between the test master and the memory slave.
interface nios_system_4a_mem_test_master_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic [3:0]        byteenable;
    logic              write;
    logic              read;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output address, chipselect, byteenable, write, read, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, chipselect, byteenable, write, read, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/nios_system_4a_mem_pattern_gen.sv
// Test pattern accumulator: loads the seed, adds STRIDE per step (mod 2^32).
module nios_system_4a_mem_pattern_gen
    import nios_system_4a_mem_pkg::*;
#(
    parameter logic [31:0] STRIDE = DEF_STRIDE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] value
);
    logic [31:0] acc_reg;

    // Load has priority so a restart on the final accept wins over the step.
    always_ff @(posedge clk) begin
        if (!reset_n)  acc_reg <= '0;
        else if (load) acc_reg <= seed;
        else if (step) acc_reg <= acc_reg + STRIDE;
    end

    assign value = acc_reg;
endmodule

// File: rtl/nios_system_4a_mem_test_master.sv
// Avalon-MM memory test master: fill, check or fill+check over a word range.
module nios_system_4a_mem_test_master
    import nios_system_4a_mem_pkg::*;
#(
    parameter int          ADDR_W    = 13,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter logic [31:0] STRIDE    = DEF_STRIDE,
    parameter int          TIMEOUT   = DEF_TIMEOUT,
    parameter int          ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err,
    output logic                  timeout_err,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    nios_system_4a_mem_test_master_if.master avm
);
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t                 state_reg, state_next;
    logic [1:0]             mode_reg;
    logic [ADDR_W-1:0]      base_reg, addr_reg;
    logic [ADDR_W:0]        count_reg, idx_reg;
    logic [31:0]            seed_reg, pat_value;
    logic [TO_W-1:0]        to_cnt_reg;
    logic                   range_err_reg, timeout_err_reg;
    logic [ERR_CNT_W-1:0]   err_count_reg;
    logic [ADDR_W-1:0]      first_err_addr_reg;
    logic [ADDR_W+1:0]      range_sum;
    logic                   range_bad, last_word, has_fill, has_check;
    logic                   wr_accept, rd_accept, rd_valid, timed_out;

    assign has_fill  = |(mode_reg & MODE_FILL);
    assign has_check = |(mode_reg & MODE_CHECK);
    assign range_sum = {2'b00, base_reg} + {1'b0, count_reg};
    assign range_bad = range_sum > (ADDR_W + 2)'(DEPTH);
    assign last_word = (idx_reg == count_reg - 1'b1);
    assign wr_accept = (state_reg == S_WR)      && !avm.waitrequest;
    assign rd_accept = (state_reg == S_RD_REQ)  && !avm.waitrequest;
    assign rd_valid  = (state_reg == S_RD_WAIT) && avm.readdatavalid;
    // A late readdatavalid on the final count still wins over the timeout.
    assign timed_out = (state_reg == S_RD_WAIT) && !avm.readdatavalid && (to_cnt_reg == TO_LAST);

    nios_system_4a_mem_pattern_gen #(.STRIDE(STRIDE)) u_pattern_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    ((state_reg == S_CHK_RANGE) || (wr_accept && last_word)),
        .step    (wr_accept || rd_valid),
        .seed    (seed_reg),
        .value   (pat_value)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = (mode != MODE_NOP) ? S_CHK_RANGE : S_FIN;
            S_CHK_RANGE: begin
                if (range_bad || count_reg == '0) state_next = S_FIN;
                else if (has_fill)                state_next = S_WR;
                else                              state_next = S_RD_REQ;
            end
            S_WR:        if (wr_accept && last_word) state_next = has_check ? S_RD_REQ : S_FIN;
            S_RD_REQ:    if (rd_accept) state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_valid)       state_next = last_word ? S_FIN : S_RD_REQ;
                else if (timed_out) state_next = S_FIN;
            end
            S_FIN:       state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Run parameters, address/index walk, timeout counter and compare results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_reg           <= '0;
            base_reg           <= '0;
            count_reg          <= '0;
            seed_reg           <= '0;
            addr_reg           <= '0;
            idx_reg            <= '0;
            to_cnt_reg         <= '0;
            range_err_reg      <= 1'b0;
            timeout_err_reg    <= 1'b0;
            err_count_reg      <= '0;
            first_err_addr_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (start && mode != MODE_NOP) begin
                    mode_reg           <= mode;
                    base_reg           <= base_addr;
                    count_reg          <= word_count;
                    seed_reg           <= seed;
                    range_err_reg      <= 1'b0;
                    timeout_err_reg    <= 1'b0;
                    err_count_reg      <= '0;
                    first_err_addr_reg <= '0;
                end
                S_CHK_RANGE: begin
                    addr_reg <= base_reg;
                    idx_reg  <= '0;
                    if (range_bad) range_err_reg <= 1'b1;
                end
                S_WR: if (wr_accept) begin
                    if (last_word) begin
                        addr_reg <= base_reg;
                        idx_reg  <= '0;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                        idx_reg  <= idx_reg + 1'b1;
                    end
                end
                S_RD_REQ: if (rd_accept) to_cnt_reg <= '0;
                S_RD_WAIT: begin
                    if (rd_valid) begin
                        if (avm.readdata != pat_value) begin
                            if (err_count_reg == '0) first_err_addr_reg <= addr_reg;
                            if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
                        end
                        addr_reg <= addr_reg + 1'b1;
                        idx_reg  <= idx_reg + 1'b1;
                    end else if (timed_out) begin
                        timeout_err_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus strobes are decoded from the state so a reset drops them on the same edge.
    assign avm.chipselect = (state_reg == S_WR) || (state_reg == S_RD_REQ);
    assign avm.write      = (state_reg == S_WR);
    assign avm.read       = (state_reg == S_RD_REQ);
    assign avm.byteenable = avm.chipselect ? 4'hF : 4'h0;
    assign avm.address    = avm.chipselect ? addr_reg : '0;
    assign avm.writedata  = (state_reg == S_WR) ? pat_value : '0;

    assign busy           = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done           = (state_reg == S_FIN);
    assign range_err      = range_err_reg;
    assign timeout_err    = timeout_err_reg;
    assign err_count      = err_count_reg;
    assign first_err_addr = first_err_addr_reg;
endmodule

// File: tb/tb_nios_system_4a_mem_test_master.sv
// Self-checking bench: randomized slave (waitrequest, read latency, bit flips)
// against a run-level model of expected writes, reads and compare results.
module tb_nios_system_4a_mem_test_master;
    import nios_system_4a_mem_pkg::*;

    localparam int          ADDR_W  = 13;
    localparam int          DEPTH   = 5120;
    localparam int          TIMEOUT = 255;
    localparam logic [31:0] STRIDE  = 32'h01010101;

    logic                clk = 1'b0;
    logic                reset_n, start;
    logic [1:0]          mode;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     word_count;
    logic [31:0]         seed;
    logic                busy, done, range_err, timeout_err;
    logic [15:0]         err_count;
    logic [ADDR_W-1:0]   first_err_addr;

    nios_system_4a_mem_test_master_if #(.ADDR_W(ADDR_W)) avm_if ();

    nios_system_4a_mem_test_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .range_err      (range_err),
        .timeout_err    (timeout_err),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .avm            (avm_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                n_vec = 0, n_fail = 0;
    logic [31:0]       mem [0:8191];
    bit                flip [0:8191];
    logic [ADDR_W-1:0] q_wr_addr [$];
    logic [31:0]       q_wr_data [$];
    logic [ADDR_W-1:0] q_rd_addr [$];
    int                wait_pct = 0, max_lat = 0;
    bit                no_resp = 0, rd_pend = 0, g_timing = 0;
    int                rd_delay = 0;
    logic [ADDR_W-1:0] rd_addr = '0;
    int                done_cnt = 0, n_cs = 0, last_evt_cyc = 0, rd_acc_cyc = 0;
    bit                prev_wstall = 0, prev_rstall = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0]       prev_data = '0;
    logic              prev_to = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
        return s + 32'(i) * STRIDE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model and per-cycle compare process, all on the falling edge.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        avm_if.readdatavalid = 1'b0;
        if (rd_pend) begin
            if (rd_delay == 0) begin
                avm_if.readdatavalid = 1'b1;
                avm_if.readdata      = mem[rd_addr] ^ {31'd0, flip[rd_addr]};
                rd_pend      = 1'b0;
                last_evt_cyc = cyc;
            end else begin
                rd_delay--;
            end
        end
        avm_if.waitrequest = ($urandom_range(0, 99) < wait_pct);
        if (reset_n) begin
            chk("byteenable", {28'd0, avm_if.byteenable}, avm_if.chipselect ? 32'hF : 32'h0);
            chk("cs_vs_strobes", avm_if.chipselect, avm_if.read | avm_if.write);
            chk("rd_wr_exclusive", avm_if.read & avm_if.write, 0);
            if (prev_wstall) begin
                chk("wr_held_write", avm_if.write, 1);
                chk("wr_held_addr", avm_if.address, prev_addr);
                chk("wr_held_data", avm_if.writedata, prev_data);
            end
            if (prev_rstall) begin
                chk("rd_held_read", avm_if.read, 1);
                chk("rd_held_addr", avm_if.address, prev_addr);
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
                if (g_timing) chk("done_latency", cyc, last_evt_cyc + 1);
            end
            if (timeout_err && !prev_to) begin
                chk("timeout_latency", cyc, rd_acc_cyc + TIMEOUT);
                chk("done_at_timeout", done, 1);
            end
            if (avm_if.chipselect) n_cs++;
            if (avm_if.write && !avm_if.waitrequest) begin
                mem[avm_if.address] = avm_if.writedata;
                last_evt_cyc = cyc;
                chk("write_expected", q_wr_addr.size() != 0, 1);
                if (q_wr_addr.size() != 0) begin
                    ea = q_wr_addr.pop_front();
                    ed = q_wr_data.pop_front();
                    chk("write_addr", avm_if.address, ea);
                    chk("write_data", avm_if.writedata, ed);
                end
            end
            if (avm_if.read && !avm_if.waitrequest) begin
                rd_acc_cyc = cyc + 1;
                chk("read_expected", q_rd_addr.size() != 0, 1);
                if (q_rd_addr.size() != 0) begin
                    ea = q_rd_addr.pop_front();
                    chk("read_addr", avm_if.address, ea);
                end
                if (!no_resp) begin
                    rd_pend  = 1'b1;
                    rd_delay = $urandom_range(0, max_lat);
                    rd_addr  = avm_if.address;
                end
            end
            prev_wstall = avm_if.write && avm_if.waitrequest;
            prev_rstall = avm_if.read && avm_if.waitrequest;
            prev_addr   = avm_if.address;
            prev_data   = avm_if.writedata;
        end else begin
            prev_wstall = 1'b0;
            prev_rstall = 1'b0;
        end
        prev_to = timeout_err;
    end

    // One complete run: build expectations, pulse start, wait for done, check results.
    task automatic run_case(input logic [1:0] m, input int b, input int c, input logic [31:0] s,
                            input int wp, input int ml, input bit nr, input bit poke);
        int          exp_err, exp_first, d0, n;
        bit          traffic, exp_rng, exp_to;
        logic [31:0] p, got;
        q_wr_addr.delete(); q_wr_data.delete(); q_rd_addr.delete();
        rd_pend = 1'b0; wait_pct = wp; max_lat = ml; no_resp = nr;
        traffic = (m != 2'b00) && (b + c <= DEPTH) && (c != 0);
        exp_rng = (m != 2'b00) && (b + c > DEPTH);
        exp_to  = traffic && m[1] && nr;
        exp_err = 0; exp_first = 0;
        if (traffic) begin
            for (int i = 0; i < c; i++) begin
                p = pat(s, i);
                if (m[0]) begin
                    q_wr_addr.push_back(ADDR_W'(b + i));
                    q_wr_data.push_back(p);
                end
                if (m[1]) begin
                    q_rd_addr.push_back(ADDR_W'(b + i));
                    got = (m[0] ? p : mem[b + i]) ^ {31'd0, flip[b + i]};
                    if (!nr && got != p) begin
                        if (exp_err == 0) exp_first = b + i;
                        exp_err++;
                    end
                end
            end
        end
        g_timing = traffic && !exp_to;
        n_cs = 0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = ADDR_W'(b); word_count = (ADDR_W + 1)'(c); seed = s;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, m != 2'b00);
        chk("done_after_start", done, m == 2'b00);
        if (poke) begin
            @(negedge clk);
            start = 1'b1; mode = 2'b01; base_addr = 7; word_count = 3;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt != d0, 1);
        repeat (3) @(negedge clk);
        chk("single_done", done_cnt, d0 + 1);
        chk("busy_idle", busy, 0);
        if (m != 2'b00) begin
            chk("range_err", range_err, exp_rng);
            chk("timeout_err", timeout_err, exp_to);
            chk("err_count", err_count, exp_err);
            if (exp_err != 0) chk("first_err_addr", first_err_addr, exp_first);
        end
        if (!traffic) chk("no_traffic", n_cs, 0);
        chk("writes_complete", q_wr_addr.size(), 0);
        if (!exp_to) chk("reads_complete", q_rd_addr.size(), 0);
        $display("run mode=%b base=%0d count=%0d seed=%h wait=%0d%% -> err_count=%0d range_err=%0b timeout_err=%0b",
                 m, b, c, s, wp, err_count, range_err, timeout_err);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        for (int i = 0; i < 8192; i++) begin
            mem[i]  = '0;
            flip[i] = 1'b0;
        end
        reset_n = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0; word_count = '0; seed = '0;
        avm_if.waitrequest = 1'b0; avm_if.readdatavalid = 1'b0; avm_if.readdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        chk("rst_cs", avm_if.chipselect, 0);
        chk("rst_write", avm_if.write, 0);
        chk("rst_read", avm_if.read, 0);
        chk("rst_byteenable", avm_if.byteenable, 0);
        chk("rst_address", avm_if.address, 0);
        chk("rst_writedata", avm_if.writedata, 0);
        reset_n = 1'b1;

        // Zero-wait fill+check of 16 words from seed 0.
        run_case(2'b11, 0, 16, 32'h0, 0, 0, 0, 0);
        chk("lit_mem15", mem[15], 32'h0F0F0F0F);
        chk("lit_mem5", mem[5], 32'h05050505);
        chk("lit_err0", err_count, 0);

        // Slave corrupts bit 0 on reads of words 5 and 9.
        flip[5] = 1'b1; flip[9] = 1'b1;
        run_case(2'b11, 0, 16, 32'h0, 0, 0, 0, 0);
        chk("lit_err2", err_count, 2);
        chk("lit_first5", first_err_addr, 5);
        chk("lit_to0", timeout_err, 0);

        // Stalled fill, then readback checks with the right and a wrong seed.
        run_case(2'b01, 100, 40, 32'hDEADBEEF, 50, 0, 0, 0);
        for (int i = 0; i < 40; i += 7) chk("mem_pattern", mem[100 + i], pat(32'hDEADBEEF, i));
        run_case(2'b10, 100, 40, 32'hDEADBEEF, 50, 3, 0, 0);
        run_case(2'b10, 100, 40, 32'h12345678, 30, 2, 0, 0);

        // Range boundary.
        run_case(2'b11, 5100, 21, 32'hA5A5A5A5, 0, 0, 0, 0);
        chk("lit_range1", range_err, 1);
        run_case(2'b11, 5100, 20, 32'hA5A5A5A5, 20, 1, 0, 0);

        // Slave never answers the read.
        run_case(2'b10, 0, 4, 32'h0, 0, 0, 1, 0);
        chk("lit_timeout1", timeout_err, 1);

        // Reset in the middle of a fill.
        q_wr_addr.delete(); q_wr_data.delete(); q_rd_addr.delete();
        wait_pct = 0; no_resp = 0; g_timing = 0;
        for (int i = 0; i < 64; i++) begin
            q_wr_addr.push_back(ADDR_W'(200 + i));
            q_wr_data.push_back(pat(32'h1, i));
        end
        @(negedge clk);
        start = 1'b1; mode = 2'b01; base_addr = 200; word_count = 64; seed = 32'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_write", avm_if.write, 1);
        d0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_write", avm_if.write, 0);
        chk("mid_rst_cs", avm_if.chipselect, 0);
        chk("mid_rst_address", avm_if.address, 0);
        chk("mid_rst_writedata", avm_if.writedata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", done_cnt, d0);
        chk("idle_after_reset", busy, 0);
        q_wr_addr.delete(); q_wr_data.delete(); rd_pend = 1'b0;

        // Start while busy is ignored; empty count and no-op mode just pulse done.
        run_case(2'b01, 300, 20, 32'h0BADF00D, 0, 0, 0, 1);
        run_case(2'b11, 10, 0, 32'h0, 0, 0, 0, 0);
        run_case(2'b00, 0, 5, 32'h0, 0, 0, 0, 0);

        // Randomized runs.
        for (int k = 0; k < 6; k++) begin
            int b, c;
            c = $urandom_range(1, 40);
            b = (k == 0) ? 5110 : $urandom_range(0, 5000);
            if (k == 0) c = $urandom_range(11, 40);
            run_case(2'($urandom_range(1, 3)), b, c, $urandom, $urandom_range(0, 60),
                     $urandom_range(0, 4), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
